// File: rtl/gp_input_conditioner_pkg.sv
// Shared constants for the general-purpose input conditioner.
// Holds the edge-mode encoding and a constant-width helper.
package gp_input_conditioner_pkg;

    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_NONE = 2'b11;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/gp_sync_filter.sv
// Synchroniser chain followed by a glitch filter on the selected source.
// Ports: clk_i/rst_i, src_i raw source, blank_i forces level to track sync,
// filter_len_i extra stable cycles, sync_o synchroniser output, level_o filtered level.
module gp_sync_filter
    import gp_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              src_i,
    input  logic              blank_i,
    input  logic [FILT_W-1:0] filter_len_i,
    output logic              sync_o,
    output logic              level_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILT_W-1:0]      cnt_q, cnt_d;
    logic                   level_q, level_d;

    assign sync_o  = sync_q[SYNC_STAGES-1];
    assign level_o = level_q;

    // Counter runs only while the synchronised value disagrees with the
    // filtered level; any agreement restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (blank_i) begin
            level_d = sync_o;
        end else if (sync_o != level_q) begin
            if (cnt_q == filter_len_i) begin
                level_d = sync_o;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], src_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/gp_input_conditioner.sv
// Selectable input conditioner: source mux, sync/filter, blanking on source
// switch, edge-selected trigger/capture pulses and a saturating event counter.
// Ports: input_i/sw_in_i sources, input_sel_i, trigger/capture_selection_i modes,
// filter_len_i, clr_i; outputs trig_o, capture_o, level_o, event_cnt_o.
module gp_input_conditioner
    import gp_input_conditioner_pkg::*;
#(
    parameter int  NUM_INPUTS  = 15,
    parameter int  SYNC_STAGES = 2,
    parameter int  FILT_W      = 4,
    parameter int  CNT_W       = 16,
    localparam int SEL_W       = clog2(NUM_INPUTS + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_INPUTS:1]   input_i,
    input  logic [SEL_W-1:0]      input_sel_i,
    input  logic                  sw_in_i,
    input  logic [1:0]            trigger_selection_i,
    input  logic [1:0]            capture_selection_i,
    input  logic [FILT_W-1:0]     filter_len_i,
    input  logic                  clr_i,
    output logic                  trig_o,
    output logic                  capture_o,
    output logic                  level_o,
    output logic [CNT_W-1:0]      event_cnt_o
);

    localparam int BLK_W = clog2(SYNC_STAGES + 1);

    logic             src;
    logic             sync_out;
    logic             level;
    logic [SEL_W-1:0] sel_q;
    logic [BLK_W-1:0] blank_q, blank_d;
    logic             sel_change;
    logic             blank;
    logic             level_prev_q;
    logic             rise, fall;
    logic             trig_q, trig_d;
    logic             cap_q, cap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic edge_hit(input logic [1:0] mode,
                                      input logic r, input logic f);
        logic hit;
        unique case (mode)
            EDGE_RISE: hit = r;
            EDGE_FALL: hit = f;
            EDGE_BOTH: hit = r | f;
            EDGE_NONE: hit = 1'b0;
        endcase
        return hit;
    endfunction

    always_comb begin
        src = 1'b0;
        if (input_sel_i == '0) begin
            src = sw_in_i;
        end else begin
            for (int k = 1; k <= NUM_INPUTS; k++) begin
                if (input_sel_i == SEL_W'(k)) src = input_i[k];
            end
        end
    end

    // A source switch blanks the path until the new source has fully
    // propagated through the synchroniser, so stale history cannot pulse.
    assign sel_change = (input_sel_i != sel_q);
    assign blank      = sel_change || (blank_q != '0);

    always_comb begin
        blank_d = '0;
        if (sel_change) begin
            blank_d = BLK_W'(SYNC_STAGES);
        end else if (blank_q != '0) begin
            blank_d = blank_q - 1'b1;
        end
    end

    gp_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_W      (FILT_W)
    ) u_sync_filter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .src_i        (src),
        .blank_i      (blank),
        .filter_len_i (filter_len_i),
        .sync_o       (sync_out),
        .level_o      (level)
    );

    assign rise = level & ~level_prev_q;
    assign fall = ~level & level_prev_q;

    always_comb begin
        trig_d = 1'b0;
        cap_d  = 1'b0;
        cnt_d  = cnt_q;
        if (input_sel_i == '0) begin
            trig_d = level;
        end else if (!blank) begin
            trig_d = edge_hit(trigger_selection_i, rise, fall);
        end
        if (!blank) begin
            cap_d = edge_hit(capture_selection_i, rise, fall);
        end
        if (clr_i) begin
            cnt_d = '0;
        end else if (cap_q && !blank && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q        <= input_sel_i;
            blank_q      <= BLK_W'(SYNC_STAGES);
            level_prev_q <= 1'b0;
            trig_q       <= 1'b0;
            cap_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sel_q        <= input_sel_i;
            blank_q      <= blank_d;
            level_prev_q <= blank ? sync_out : level;
            trig_q       <= trig_d;
            cap_q        <= cap_d;
            cnt_q        <= cnt_d;
        end
    end

    assign trig_o      = trig_q;
    assign capture_o   = cap_q;
    assign level_o     = level;
    assign event_cnt_o = cnt_q;

endmodule

// File: doc/gp_input_conditioner.md
GP_INPUT_CONDITIONER -- requirements
Module: gp_input_conditioner

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 15, the number of selectable external inputs.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the synchroniser depth; minimum 2.
REQ-003 The block SHALL have parameter FILT_W, default 4, the glitch-filter length field width.
REQ-004 The block SHALL have parameter CNT_W, default 16, the event counter width.
REQ-005 The block SHALL have derived constant SEL_W = clog2(NUM_INPUTS+1).
REQ-006 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit, reset; reset is synchronous and active-high.
REQ-008 The block SHALL have port input_i, input, NUM_INPUTS bits (indices NUM_INPUTS:1), external asynchronous inputs.
REQ-009 The block SHALL have port input_sel_i, input, SEL_W bits: 0 selects sw_in_i; k selects input_i[k]; k > NUM_INPUTS selects constant 0.
REQ-010 The block SHALL have port sw_in_i, input, 1 bit, software level source.
REQ-011 The block SHALL have port trigger_selection_i, input, 2 bits: 00 rising, 01 falling, 10 both, 11 none.
REQ-012 The block SHALL have port capture_selection_i, input, 2 bits, same encoding as trigger_selection_i.
REQ-013 The block SHALL have port filter_len_i, input, FILT_W bits, the number of extra stable cycles required before the filtered level changes.
REQ-014 The block SHALL have port clr_i, input, 1 bit, which clears the event counter.
REQ-015 The block SHALL have port trig_o, output, 1 bit, a registered trigger pulse (or the filtered level when input_sel_i = 0).
REQ-016 The block SHALL have port capture_o, output, 1 bit, a registered one-cycle capture pulse.
REQ-017 The block SHALL have port level_o, output, 1 bit, the filtered level.
REQ-018 The block SHALL have port event_cnt_o, output, CNT_W bits, the saturating count of capture_o pulses.

Function
REQ-019 The selected source SHALL pass through a SYNC_STAGES-deep flop chain; the sync output reflects a source change SYNC_STAGES edges later.
REQ-020 Glitch filter: a counter SHALL increment while sync_out != level_o and clear when they are equal; when the counter equals filter_len_i, level_o <= sync_out and the counter clears.
REQ-021 With filter_len_i = 0, level_o SHALL follow sync_out with exactly 1 cycle delay; a sync_out pulse of n <= filter_len_i cycles SHALL NOT change level_o.
REQ-022 The block SHALL keep level_prev as level_o delayed 1 cycle; rise = level_o & ~level_prev; fall = ~level_o & level_prev.
REQ-023 capture_o SHALL be registered from the capture_selection_i-selected edge, is high for exactly 1 cycle per edge, and is never high for mode 11.
REQ-024 For input_sel_i != 0, trig_o SHALL be registered from the trigger_selection_i-selected edge; for input_sel_i = 0, trig_o SHALL be level_o registered.
REQ-025 Latency: source change to trig_o/capture_o SHALL be SYNC_STAGES + filter_len_i + 2 rising edges (4 with defaults and filter 0).
REQ-026 Blanking: a registered compare SHALL detect an input_sel_i change; it loads a blank counter with SYNC_STAGES, which decrements to 0.
REQ-027 While the blank counter is nonzero, level_o and level_prev SHALL load sync_out directly, the filter counter is held at 0, and trig_o edge pulses, capture_o and counting are suppressed.
REQ-028 event_cnt_o SHALL increment on each capture_o pulse and saturate at all ones.
REQ-029 clr_i SHALL take priority over an increment in the same cycle, giving a result of 0.
REQ-030 The block SHALL sample mode inputs every cycle; a mode change takes effect on the next registered pulse with no state reset.

Reset
REQ-031 While rst_i is high at a clock edge, the sync chain, level_o, level_prev, filter counter, trig_o, capture_o and event_cnt_o SHALL go to 0, and the blank counter SHALL load SYNC_STAGES.
REQ-032 Reset asserted mid-filter or mid-pulse SHALL abort the operation; no pulse is emitted from state held before reset.

Structure
REQ-033 A shared package SHALL hold the edge-mode encoding constants (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_NONE) and a clog2 helper.
REQ-034 The block SHALL use one sub-module, gp_sync_filter (synchroniser plus glitch filter, parametrised by SYNC_STAGES and FILT_W); the selection mux, blanking, edge logic and counter SHALL sit in the top level.

Verification
REQ-035 Scenario: sel=3, filter 0, modes 00/00, input_i[3] rises -> trig_o and capture_o pulse 1 cycle, 4 edges after the change, and event_cnt_o=1.
REQ-036 Scenario: filter_len_i=3, input_i[3] pulses 3 cycles -> no change on level_o and no pulse; a 5-cycle pulse -> level_o rises after 2+4 edges.
REQ-037 Scenario: capture mode 10, trigger mode 11, input toggles 0->1->0 -> 2 capture_o pulses and trig_o stays 0.
REQ-038 Scenario: sel switches 2->5 with input_i[2]=0 and input_i[5]=1 -> no pulse during the 2 blanking cycles and level_o=1 after them.
REQ-039 Scenario: CNT_W=4, 17 edges -> event_cnt_o holds at 15; clr_i together with an edge -> 0.
REQ-040 Scenario: sel=0, sw_in_i=1 -> trig_o=1 after SYNC_STAGES+2 edges; rst_i mid-filter -> all outputs 0 on the next edge.
